// File: rtl/me_frame_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// me_frame_feeder_pkg : shared FSM encoding and block geometry constants
// Revision: 1.0
// ---------------------------------------------------------------------------
package me_frame_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_CUR = 2'd1,
    ST_WAIT_REQ = 2'd2,
    ST_LOAD_SRC = 2'd3
  } state_t;

  localparam int BLK_SIZE      = 16;
  localparam int WORDS_PER_BLK = 32;
  localparam int PIX_PER_WORD  = 8;

endpackage
`default_nettype wire

// File: rtl/me_addr_clamp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// me_addr_clamp : search-window address with the window clamped to the frame
// Revision: 1.0
// ---------------------------------------------------------------------------
module me_addr_clamp #(
  parameter int FRAME_W  = 352,
  parameter int FRAME_H  = 288,
  parameter int REF_BASE = 101376,
  parameter int ADDR_W   = 18
) (
  input  logic [15:0]        base_x,
  input  logic [15:0]        base_y,
  input  logic signed [6:0]  mv_x,
  input  logic signed [6:0]  mv_y,
  output logic [ADDR_W-1:0]  addr
);

  int x_w;
  int y_w;

  always_comb begin
    x_w = int'(base_x) + int'(mv_x);
    y_w = int'(base_y) + int'(mv_y);
    // X stops at FRAME_W-8 so the whole 8-pixel word stays inside the row
    if (x_w < 0)                 x_w = 0;
    else if (x_w > FRAME_W - 8)  x_w = FRAME_W - 8;
    if (y_w < 0)                 y_w = 0;
    else if (y_w > FRAME_H - 1)  y_w = FRAME_H - 1;
    addr = ADDR_W'(REF_BASE + y_w * FRAME_W + x_w);
  end

endmodule
`default_nettype wire

// File: rtl/me_frame_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// me_frame_feeder : streams current and search 16x16 blocks to the ME core
// Revision: 1.0
// ---------------------------------------------------------------------------
module me_frame_feeder
  import me_frame_feeder_pkg::*;
#(
  parameter int FRAME_W  = 352,
  parameter int FRAME_H  = 288,
  parameter int CUR_BASE = 0,
  parameter int REF_BASE = 101376,
  parameter int ADDR_W   = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               search_WE_req,
  input  logic signed [6:0]  mv_x,
  input  logic signed [6:0]  mv_y,
  input  logic               blockend,
  output logic               mem_re,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [63:0]        mem_data,
  output logic               cur_WE,
  output logic               search_WE,
  output logic [63:0]        data_out,
  output logic               curfilled,
  output logic               srcfilled,
  output logic               frame_done,
  output logic               busy
);

  localparam int NBX  = FRAME_W / BLK_SIZE;
  localparam int NBY  = FRAME_H / BLK_SIZE;
  localparam int BX_W = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int BY_W = (NBY > 1) ? $clog2(NBY) : 1;

  state_t             state_q, state_d;
  logic [BX_W-1:0]    bx_q, bx_d;
  logic [BY_W-1:0]    by_q, by_d;
  logic [4:0]         word_q, word_d;
  logic [4:0]         cur_cnt_q, cur_cnt_d;
  logic [4:0]         src_cnt_q, src_cnt_d;
  logic               cur_we_q, cur_we_d;
  logic               src_we_q, src_we_d;
  logic               curfilled_q, curfilled_d;
  logic               srcfilled_q, srcfilled_d;
  logic               frame_done_q, frame_done_d;
  logic               req_pend_q, req_pend_d;
  logic               be_pend_q, be_pend_d;
  logic signed [6:0]  pmv_x_q, pmv_x_d, pmv_y_q, pmv_y_d;
  logic signed [6:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;

  logic               eff_req;
  logic               eff_be;
  logic               last_blk;
  logic [15:0]        base_x;
  logic [15:0]        base_y;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  src_addr;

  assign eff_req  = search_WE_req | req_pend_q;
  assign eff_be   = blockend | be_pend_q;
  assign last_blk = (bx_q == BX_W'(NBX - 1)) && (by_q == BY_W'(NBY - 1));

  assign base_x   = 16'(int'(bx_q) * BLK_SIZE + int'(word_q[0]) * PIX_PER_WORD);
  assign base_y   = 16'(int'(by_q) * BLK_SIZE + int'(word_q[4:1]));
  assign cur_addr = ADDR_W'(CUR_BASE + int'(base_y) * FRAME_W + int'(base_x));

  me_addr_clamp #(
    .FRAME_W  (FRAME_W),
    .FRAME_H  (FRAME_H),
    .REF_BASE (REF_BASE),
    .ADDR_W   (ADDR_W)
  ) u_clamp (
    .base_x (base_x),
    .base_y (base_y),
    .mv_x   (mv_x_q),
    .mv_y   (mv_y_q),
    .addr   (src_addr)
  );

  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    word_d       = word_q;
    cur_cnt_d    = cur_cnt_q;
    src_cnt_d    = src_cnt_q;
    cur_we_d     = (state_q == ST_LOAD_CUR);
    src_we_d     = (state_q == ST_LOAD_SRC);
    curfilled_d  = curfilled_q;
    srcfilled_d  = srcfilled_q;
    frame_done_d = 1'b0;
    req_pend_d   = req_pend_q;
    be_pend_d    = be_pend_q;
    pmv_x_d      = pmv_x_q;
    pmv_y_d      = pmv_y_q;
    mv_x_d       = mv_x_q;
    mv_y_d       = mv_y_q;

    if (cur_we_q) begin
      cur_cnt_d = cur_cnt_q + 5'd1;
      if (cur_cnt_q == 5'(WORDS_PER_BLK - 1)) curfilled_d = 1'b1;
    end
    if (src_we_q) begin
      src_cnt_d = src_cnt_q + 5'd1;
      if (src_cnt_q == 5'(WORDS_PER_BLK - 1)) srcfilled_d = 1'b1;
    end

    if (state_q != ST_WAIT_REQ) begin
      if (search_WE_req) begin
        req_pend_d = 1'b1;
        pmv_x_d    = mv_x;
        pmv_y_d    = mv_y;
      end
      if (blockend) be_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_CUR;
          bx_d    = '0;
          by_d    = '0;
          word_d  = '0;
        end
      end
      ST_LOAD_CUR, ST_LOAD_SRC: begin
        word_d = word_q + 5'd1;
        if (word_q == 5'(WORDS_PER_BLK - 1)) state_d = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        word_d = '0;
        // blockend outranks any request: the request is dropped
        if (eff_be) begin
          be_pend_d   = 1'b0;
          req_pend_d  = 1'b0;
          curfilled_d = 1'b0;
          if (last_blk) begin
            state_d      = ST_IDLE;
            bx_d         = '0;
            by_d         = '0;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD_CUR;
            if (bx_q == BX_W'(NBX - 1)) begin
              bx_d = '0;
              by_d = by_q + 1'b1;
            end else begin
              bx_d = bx_q + 1'b1;
            end
          end
        end else if (eff_req) begin
          req_pend_d  = 1'b0;
          srcfilled_d = 1'b0;
          mv_x_d      = search_WE_req ? mv_x : pmv_x_q;
          mv_y_d      = search_WE_req ? mv_y : pmv_y_q;
          state_d     = ST_LOAD_SRC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bx_q         <= '0;
      by_q         <= '0;
      word_q       <= '0;
      cur_cnt_q    <= '0;
      src_cnt_q    <= '0;
      cur_we_q     <= 1'b0;
      src_we_q     <= 1'b0;
      curfilled_q  <= 1'b0;
      srcfilled_q  <= 1'b0;
      frame_done_q <= 1'b0;
      req_pend_q   <= 1'b0;
      be_pend_q    <= 1'b0;
      pmv_x_q      <= '0;
      pmv_y_q      <= '0;
      mv_x_q       <= '0;
      mv_y_q       <= '0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      word_q       <= word_d;
      cur_cnt_q    <= cur_cnt_d;
      src_cnt_q    <= src_cnt_d;
      cur_we_q     <= cur_we_d;
      src_we_q     <= src_we_d;
      curfilled_q  <= curfilled_d;
      srcfilled_q  <= srcfilled_d;
      frame_done_q <= frame_done_d;
      req_pend_q   <= req_pend_d;
      be_pend_q    <= be_pend_d;
      pmv_x_q      <= pmv_x_d;
      pmv_y_q      <= pmv_y_d;
      mv_x_q       <= mv_x_d;
      mv_y_q       <= mv_y_d;
    end
  end

  always_comb begin
    mem_re   = 1'b0;
    mem_addr = '0;
    if (state_q == ST_LOAD_CUR) begin
      mem_re   = 1'b1;
      mem_addr = cur_addr;
    end else if (state_q == ST_LOAD_SRC) begin
      mem_re   = 1'b1;
      mem_addr = src_addr;
    end
  end

  // memory data arrives exactly with the registered strobe, so it passes straight through
  assign data_out   = (cur_we_q | src_we_q) ? mem_data : 64'd0;
  assign cur_WE     = cur_we_q;
  assign search_WE  = src_we_q;
  assign curfilled  = curfilled_q;
  assign srcfilled  = srcfilled_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_me_frame_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_me_frame_feeder : scoreboard bench on a 32x32 frame (2x2 blocks)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_me_frame_feeder;

  localparam int FW = 32;
  localparam int FH = 32;
  localparam int CB = 0;
  localparam int RB = 101376;
  localparam int AW = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              search_WE_req = 1'b0;
  logic signed [6:0] mv_x = '0;
  logic signed [6:0] mv_y = '0;
  logic              blockend = 1'b0;
  logic              mem_re;
  logic [AW-1:0]     mem_addr;
  logic [63:0]       mem_data = '0;
  logic              cur_WE, search_WE;
  logic [63:0]       data_out;
  logic              curfilled, srcfilled, frame_done, busy;

  int n_vec = 0;
  int n_err = 0;
  int fd_cnt = 0;

  logic [AW-1:0] exp_rd[$];
  logic [64:0]   exp_wr[$];   // bit 64: 1 = search write

  me_frame_feeder #(
    .FRAME_W(FW), .FRAME_H(FH), .CUR_BASE(CB), .REF_BASE(RB), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .search_WE_req(search_WE_req),
    .mv_x(mv_x), .mv_y(mv_y), .blockend(blockend), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_data(mem_data), .cur_WE(cur_WE),
    .search_WE(search_WE), .data_out(data_out), .curfilled(curfilled),
    .srcfilled(srcfilled), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [AW-1:0] a);
    return {14'h0, a, 14'h1555, a ^ 18'h2AAAA};
  endfunction

  always @(posedge clk) mem_data <= mem_re ? pat(mem_addr) : 64'h0;

  function automatic int cur_a(input int bx, input int by, input int w);
    return CB + (16 * by + w / 2) * FW + 16 * bx + 8 * (w % 2);
  endfunction

  function automatic int src_a(input int bx, input int by, input int w,
                               input int mvx, input int mvy);
    int x, y;
    x = 16 * bx + 8 * (w % 2) + mvx;
    y = 16 * by + w / 2 + mvy;
    if (x < 0) x = 0; else if (x > FW - 8) x = FW - 8;
    if (y < 0) y = 0; else if (y > FH - 1) y = FH - 1;
    return RB + y * FW + x;
  endfunction

  task automatic push_cur(input int bx, input int by);
    logic [AW-1:0] a;
    for (int w = 0; w < 32; w++) begin
      a = AW'(cur_a(bx, by, w));
      exp_rd.push_back(a);
      exp_wr.push_back({1'b0, pat(a)});
    end
  endtask

  task automatic push_src(input int bx, input int by, input int mvx, input int mvy,
                          input int n_rd, input int n_wr);
    logic [AW-1:0] a;
    for (int w = 0; w < 32; w++) begin
      a = AW'(src_a(bx, by, w, mvx, mvy));
      if (w < n_rd) exp_rd.push_back(a);
      if (w < n_wr) exp_wr.push_back({1'b1, pat(a)});
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (mem_re === 1'b1) begin
      n_vec++;
      if (exp_rd.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got addr %0d, required no read", mem_addr);
      end else begin
        logic [AW-1:0] e;
        e = exp_rd.pop_front();
        if (mem_addr !== e) begin
          n_err++;
          $display("FAIL read_addr: got %0d, required %0d", mem_addr, e);
        end
      end
    end
    if (cur_WE === 1'b1 || search_WE === 1'b1) begin
      n_vec++;
      if (exp_wr.size() == 0 || (cur_WE && search_WE)) begin
        n_err++;
        $display("FAIL unexpected_write: got cur_WE=%0b search_WE=%0b, required none",
                 cur_WE, search_WE);
      end else begin
        logic [64:0] e;
        e = exp_wr.pop_front();
        if ({search_WE, data_out} !== e) begin
          n_err++;
          $display("FAIL write: got src=%0b data=%h, required src=%0b data=%h",
                   search_WE, data_out, e[64], e[63:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  task automatic wait_level(input bit src, input logic val, input string nm);
    int k;
    k = 0;
    while (((src ? srcfilled : curfilled) !== val) && k < 200) begin
      tick();
      k++;
    end
    check(nm, {63'd0, src ? srcfilled : curfilled}, {63'd0, val});
  endtask

  task automatic pulse_be();
    blockend = 1'b1;
    tick();
    blockend = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outputs",
          {mem_re, 7'd0, mem_addr, cur_WE, search_WE, curfilled, srcfilled, frame_done, busy},
          64'd0);
    check("reset_data_out", data_out, 64'd0);
    reset = 1'b0;
    tick();

    // block (0,0) current load: addresses 0,8,32,...,488
    push_cur(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    repeat (32) tick();
    check("curfilled_before_33", {62'd0, curfilled, cur_WE}, 64'd1);
    tick();
    check("curfilled_after_33", {62'd0, curfilled, cur_WE}, 64'd2);

    // block (0,0) search with mv (-8,-8): clamps to REF_BASE; MV must be latched
    push_src(0, 0, -8, -8, 32, 32);
    search_WE_req = 1'b1; mv_x = -7'sd8; mv_y = -7'sd8;
    tick();
    search_WE_req = 1'b0; mv_x = 7'sd20; mv_y = 7'sd20;
    wait_level(1'b1, 1'b1, "src00_filled");

    // next block (1,0); two requests during LOAD_CUR, the second must win
    push_cur(1, 0);
    push_src(1, 0, 15, 0, 32, 32);
    pulse_be();
    check("curfilled_falls", {63'd0, curfilled}, 64'd0);
    repeat (4) tick();
    search_WE_req = 1'b1; mv_x = 7'sd5; mv_y = 7'sd5;
    tick();
    mv_x = 7'sd15; mv_y = 7'sd0;
    tick();
    search_WE_req = 1'b0; mv_x = -7'sd30; mv_y = 7'sd9;
    wait_level(1'b1, 1'b0, "src10_falls");
    wait_level(1'b1, 1'b1, "src10_filled");
    check("cur10_filled", {63'd0, curfilled}, 64'd1);

    // block (0,1), then request with blockend in the same cycle
    push_cur(0, 1);
    pulse_be();
    wait_level(1'b0, 1'b1, "cur01_filled");
    push_cur(1, 1);
    search_WE_req = 1'b1; blockend = 1'b1; mv_x = 7'sd1; mv_y = 7'sd1;
    tick();
    search_WE_req = 1'b0; blockend = 1'b0;
    check("cur_falls_on_tie", {63'd0, curfilled}, 64'd0);
    wait_level(1'b0, 1'b1, "cur11_filled");
    check("src_kept_on_tie", {63'd0, srcfilled}, 64'd1);

    // block (1,1) search with mv (+3,-2): first address REF_BASE+14*32+19
    push_src(1, 1, 3, -2, 32, 32);
    search_WE_req = 1'b1; mv_x = 7'sd3; mv_y = -7'sd2;
    tick();
    search_WE_req = 1'b0; mv_x = 7'sd0; mv_y = 7'sd0;
    check("src11_low", {63'd0, srcfilled}, 64'd0);
    wait_level(1'b1, 1'b1, "src11_filled");

    // last blockend ends the frame
    pulse_be();
    check("frame_done_pulse", {62'd0, frame_done, busy}, 64'd2);
    tick();
    check("frame_done_low", {62'd0, frame_done, busy}, 64'd0);
    start = 1'b1;
    push_cur(0, 0);
    tick();
    start = 1'b0;
    wait_level(1'b0, 1'b1, "restart_filled");

    // reset at word 17 of a search load
    push_src(0, 0, 0, 0, 18, 17);
    search_WE_req = 1'b1;
    tick();
    search_WE_req = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    check("midload_reset_outputs",
          {mem_re, 7'd0, mem_addr, cur_WE, search_WE, curfilled, srcfilled, frame_done, busy},
          64'd0);
    check("midload_reset_data", data_out, 64'd0);
    reset = 1'b0;
    tick();
    push_cur(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_level(1'b0, 1'b1, "post_reset_filled");
    repeat (3) tick();

    check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("frame_done_count", 64'(fd_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
